// File: rtl/io_uart_bridge.sv
// io_uart_bridge: command/status bridge between the core's ioout/ioin port
// pair and an 8N1 UART, with a 4-entry receive FIFO. Commands are handed over
// with a toggle bit, so each store to ioout runs exactly one command.
module io_uart_bridge #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] ioout,
   output logic [15:0] ioin,
   input  logic        uart_rx,
   output logic        uart_tx
);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

   localparam int            CW        = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [2:0]    CMD_TX    = 3'b001;
   localparam logic [2:0]    CMD_POP   = 3'b010;
   localparam logic [2:0]    CMD_CLEAR = 3'b011;
   localparam logic [2:0]    FIFO_FULL = 3'(FIFO_DEPTH);

   // command interface
   logic [15:0] req_q;
   logic        ack;
   logic        pending;
   logic [2:0]  cmd;
   logic [7:0]  wdata;
   logic        unused_bits;

   assign pending     = req_q[15] ^ ack;
   assign cmd         = req_q[14:12];
   assign wdata       = req_q[7:0];
   assign unused_bits = ^req_q[11:8];

   // transmitter
   uart_state_t   tx_state, tx_state_d;
   logic [CW-1:0] tx_cnt, tx_cnt_d;
   logic [2:0]    tx_bit, tx_bit_d;
   logic [7:0]    tx_shreg, tx_shreg_d;
   logic          tx_busy;
   logic          tx_ready;
   logic          tx_load;

   // A new frame may load while idle or on the last cycle of the stop bit,
   // which gives back-to-back frames with no idle gap.
   assign tx_ready = (tx_state == S_IDLE) ||
                     ((tx_state == S_STOP) && (tx_cnt == BIT_LAST));
   assign tx_load  = pending && (cmd == CMD_TX) && tx_ready;

   // receiver
   logic          rx_s1, rx_s2, rx_d;
   uart_state_t   rx_state, rx_state_d;
   logic [CW-1:0] rx_cnt, rx_cnt_d;
   logic [2:0]    rx_bit, rx_bit_d;
   logic [7:0]    rx_shreg, rx_shreg_d;
   logic          rx_push;
   logic          rx_frm_err;

   // FIFO
   logic [7:0] mem [FIFO_DEPTH];
   logic [1:0] wr_ptr, rd_ptr;
   logic [2:0] count;
   logic       rx_err, pop_err;
   logic [7:0] rdata;
   logic       clr_cmd, pop_cmd, do_pop, do_push, push_drop;

   assign clr_cmd   = pending && (cmd == CMD_CLEAR);
   assign pop_cmd   = pending && (cmd == CMD_POP);
   assign do_pop    = pop_cmd && (count != 3'd0);
   assign do_push   = rx_push && !clr_cmd && (count != FIFO_FULL);
   assign push_drop = rx_push && !clr_cmd && (count == FIFO_FULL);

   assign ioin = {ack, (count != 3'd0), tx_busy, rx_err, pop_err, count, rdata};

   // TX state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= S_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
      end else begin
         tx_state <= tx_state_d;
         tx_cnt   <= tx_cnt_d;
         tx_bit   <= tx_bit_d;
      end
   end

   // TX shift register holds payload only, no reset needed
   always_ff @(posedge clk) begin
      tx_shreg <= tx_shreg_d;
   end

   // TX next-state: walk start, 8 data bits LSB first, stop
   always_comb begin
      tx_state_d = tx_state;
      tx_cnt_d   = tx_cnt + CW'(1);
      tx_bit_d   = tx_bit;
      tx_shreg_d = tx_shreg;
      case (tx_state)
         S_IDLE: tx_cnt_d = '0;
         S_START: begin
            if (tx_cnt == BIT_LAST) begin
               tx_state_d = S_DATA;
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
            end
         end
         S_DATA: begin
            if (tx_cnt == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_shreg_d = {1'b0, tx_shreg[7:1]};
               if (tx_bit == 3'd7) tx_state_d = S_STOP;
               else                tx_bit_d   = tx_bit + 3'd1;
            end
         end
         S_STOP: begin
            if (tx_cnt == BIT_LAST) begin
               tx_state_d = S_IDLE;
               tx_cnt_d   = '0;
            end
         end
         default: tx_state_d = S_IDLE;
      endcase
      if (tx_load) begin
         tx_state_d = S_START;
         tx_cnt_d   = '0;
         tx_shreg_d = wdata;
      end
   end

   // TX outputs: line level decoded from state so reset forces it high at once
   always_comb begin
      uart_tx = 1'b1;
      tx_busy = (tx_state != S_IDLE);
      case (tx_state)
         S_START: uart_tx = 1'b0;
         S_DATA:  uart_tx = tx_shreg[0];
         default: uart_tx = 1'b1;
      endcase
   end

   // RX synchronizer and state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_d     <= 1'b1;
         rx_state <= S_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
      end else begin
         rx_s1    <= uart_rx;
         rx_s2    <= rx_s1;
         rx_d     <= rx_s2;
         rx_state <= rx_state_d;
         rx_cnt   <= rx_cnt_d;
         rx_bit   <= rx_bit_d;
      end
   end

   // RX shift register holds payload only, no reset needed
   always_ff @(posedge clk) begin
      rx_shreg <= rx_shreg_d;
   end

   // RX next-state: half-bit start check, then sample mid-bit every bit time
   always_comb begin
      rx_state_d = rx_state;
      rx_cnt_d   = rx_cnt + CW'(1);
      rx_bit_d   = rx_bit;
      rx_shreg_d = rx_shreg;
      rx_push    = 1'b0;
      rx_frm_err = 1'b0;
      case (rx_state)
         S_IDLE: begin
            rx_cnt_d = '0;
            if (rx_d && !rx_s2) rx_state_d = S_START;
         end
         S_START: begin
            if (rx_cnt == HALF_LAST) begin
               rx_cnt_d = '0;
               rx_bit_d = '0;
               // line back high at mid start bit means a glitch, not a frame
               rx_state_d = rx_s2 ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (rx_cnt == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_shreg_d = {rx_s2, rx_shreg[7:1]};
               if (rx_bit == 3'd7) rx_state_d = S_STOP;
               else                rx_bit_d   = rx_bit + 3'd1;
            end
         end
         S_STOP: begin
            if (rx_cnt == BIT_LAST) begin
               rx_state_d = S_IDLE;
               rx_cnt_d   = '0;
               rx_push    = rx_s2;
               rx_frm_err = !rx_s2;
            end
         end
         default: rx_state_d = S_IDLE;
      endcase
   end

   // FIFO storage, written only on an accepted push
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= rx_shreg;
   end

   // command execution, FIFO bookkeeping and status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q   <= '0;
         ack     <= 1'b0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         rx_err  <= 1'b0;
         pop_err <= 1'b0;
         rdata   <= '0;
      end else begin
         req_q <= ioout;
         if (tx_load || (pending && (cmd != CMD_TX))) ack <= ~ack;
         if (clr_cmd) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rx_err  <= 1'b0;
            pop_err <= 1'b0;
            rdata   <= '0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + 2'd1;
            if (do_pop) begin
               rd_ptr <= rd_ptr + 2'd1;
               rdata  <= mem[rd_ptr];
            end else if (pop_cmd) begin
               rdata   <= '0;
               pop_err <= 1'b1;
            end
            count <= count + {2'b00, do_push} - {2'b00, do_pop};
            if (push_drop || rx_frm_err) rx_err <= 1'b1;
         end
      end
   end

endmodule
